programmable_sequence_recognizer: RTL
=====================================

# programmable_sequence_recognizer

Parametrised Mealy sequence recognizer: detects a programmable sequence of up to N symbols, each W bits wide, on a qualified input stream. It supports run-time pattern and length loading, overlapping and non-overlapping detection, a registered copy of the match output, and a saturating match counter. It sits on the same input-symbol path as the fixed 3-symbol recognizers and replaces them wherever the pattern must change without re-synthesis.

## Interface
- W, 2, symbol width in bits (1..8)
- N, 3, maximum sequence length in symbols (2..16)
- CW, 8, match counter width
- PAT_INIT, {2'b11,2'b01,2'b10}, reset pattern, N*W bits; first symbol in the MSBs

- Ck  in  1  clock, rising edge
- reset_  in  1  reset, asynchronous, active-low
- X  in  W  input symbol
- X_valid  in  1  X is a valid symbol this cycle
- OVL  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_we  in  1  load cfg_pat/cfg_len at this edge
- cfg_pat  in  N*W  new pattern; P[0] = bits [N*W-1 -: W]
- cfg_len  in  clog2(N)+1  new length L
- cnt_clr  in  1  synchronous clear of match_cnt
- Z  out  1  combinational Mealy match
- Z_q  out  1  Z registered
- match_cnt  out  CW  saturating match count

## Operation
- State: pattern P[0..N-1], length L, history H[0..N-2] (H[0] = most recent accepted symbol), fill counter F (0..N-1, saturating).
- Reset (reset_=0, async): P=PAT_INIT, L=N, H all 0, F=0, Z_q=0, match_cnt=0; Z forced 0 while reset_=0.
- Z=1 iff reset_=1, cfg_we=0, X_valid=1, F>=L-1, X==P[L-1] and H[j]==P[L-2-j] for j=0..L-2. For L=1, Z depends only on X==P[0].
- Accepted symbol (X_valid=1, cfg_we=0) at the edge: H shifts (H[j+1]<=H[j], H[0]<=X).
  - Z=1 and OVL=0: F<=0.
  - Otherwise: F<=min(F+1, N-1).
- X_valid=0: H and F hold; Z=0. Idle cycles do not break a partial match.
- cfg_we=1: P<=cfg_pat, L<=clamp(cfg_len, 1, N) (0 loads as 1, >N loads as N), F<=0; X is ignored that cycle. cfg_we wins over X_valid.
- match_cnt: on an edge with cnt_clr=1 -> 0 (clr wins over a simultaneous match); else on Z=1 -> +1, holding at 2^CW-1.
- Z_q<=Z at every edge.
- OVL may change on any cycle; it takes effect on the edge at which it is sampled.

## Timing
- Z: zero latency, combinational from X, X_valid, cfg_we, reset_ and state. Downstream logic must sample it at the next rising edge.
- Z_q, match_cnt, H, F: updated at the rising edge of Ck. Z_q lags Z by exactly one cycle.
- After cfg_we, the first match is possible on the L-th accepted symbol after the load edge.
- reset_ deassertion is synchronised externally. reset_ asserted mid-sequence discards the partial match, and Z drops immediately.
- Back-to-back matches in overlapping mode can assert Z on consecutive accepted symbols, e.g. pattern 11,11.

## Test plan
- Defaults (W=2, N=3): X = 00,11,01,10 with X_valid=1 every cycle -> Z=1 only in the 10 cycle; Z_q=1 one cycle later; match_cnt=1.
- Gaps: X = 11, (X_valid=0, X=10), 01, 10 -> single match on the final 10; the invalid 10 does not match or shift.
- Overlap: load cfg_pat = 11,11,xx with cfg_len=2, then stream 11,11,11. With OVL=1 -> Z=1 on the 2nd and 3rd symbols, match_cnt=2. With OVL=0 -> Z=1 on the 2nd only, match_cnt=1.
- Reconfig mid-stream: stream 11,01, then cfg_we with pattern 01,10,xx and L=2 while X_valid=1 and X=10 -> no match that cycle; then 01,10 -> Z=1 on the 10. Also check cfg_len=0 -> L=1, and cfg_len=5 -> L=3.
- Reset mid-operation: stream 11,01, then pulse reset_ low between edges -> Z=0 and match_cnt=0 immediately; after release, 10 alone -> no match.
- Saturation (CW=2): 5 matches -> match_cnt stays at 3. cnt_clr coincident with a match -> match_cnt=0.

Source files
------------

// File: rtl/programmable_sequence_recognizer.sv
// Programmable Mealy sequence recognizer: matches a run-time loadable pattern of
// up to N W-bit symbols on a qualified stream, with registered match and counter.
`timescale 1ns/1ps
module programmable_sequence_recognizer #(
    parameter int W = 2,
    parameter int N = 3,
    parameter int CW = 8,
    parameter logic [N*W-1:0] PAT_INIT = {2'b11, 2'b01, 2'b10}
) (
    input  logic                  Ck,
    input  logic                  reset_,
    input  logic [W-1:0]          X,
    input  logic                  X_valid,
    input  logic                  OVL,
    input  logic                  cfg_we,
    input  logic [N*W-1:0]        cfg_pat,
    input  logic [$clog2(N):0]    cfg_len,
    input  logic                  cnt_clr,
    output logic                  Z,
    output logic                  Z_q,
    output logic [CW-1:0]         match_cnt
);
    localparam int LW = $clog2(N) + 1;
    localparam int FW = $clog2(N);
    localparam logic [LW-1:0] L_MAX   = LW'(N);
    localparam logic [FW-1:0] F_MAX   = FW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N*W-1:0] pat;
    logic [LW-1:0]  len;
    logic [LW-1:0]  len_next;
    logic [FW-1:0]  fill;
    logic [W-1:0]   hist [N-1];
    logic [W-1:0]   sym  [N];
    logic           hist_ok;
    logic           last_ok;
    logic           fill_ok;

    // P[0] lives in the MSBs of the packed pattern.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sym[i] = pat[(N-i)*W-1 -: W];
        end
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        hist_ok = 1'b1;
        last_ok = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == int'(len) - 1) last_ok = (X == sym[k]);
        end
        for (int j = 0; j < N - 1; j++) begin
            for (int k = 0; k < N - 1; k++) begin
                if (j <= int'(len) - 2 && k == int'(len) - 2 - j && hist[j] != sym[k])
                    hist_ok = 1'b0;
            end
        end
    end

    assign fill_ok = int'(fill) >= int'(len) - 1;
    assign Z = reset_ & ~cfg_we & X_valid & fill_ok & hist_ok & last_ok;

    always_comb begin
        len_next = cfg_len;
        if (cfg_len == '0)        len_next = LW'(1);
        else if (cfg_len > L_MAX) len_next = L_MAX;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge Ck or negedge reset_) begin
        if (!reset_) begin
            pat  <= PAT_INIT;
            len  <= L_MAX;
            fill <= '0;
            // NOTE: the history array is reset explicitly; its zero value is
            // architecturally visible, so it is not left as uninitialised storage.
            for (int j = 0; j < N - 1; j++) hist[j] <= '0;
        end else if (cfg_we) begin
            pat  <= cfg_pat;
            len  <= len_next;
            fill <= '0;
        end else if (X_valid) begin
            for (int j = N - 2; j > 0; j--) hist[j] <= hist[j-1];
            hist[0] <= X;
            if (Z && !OVL)          fill <= '0;
            else if (fill != F_MAX) fill <= fill + 1'b1;
        end
    end

    always_ff @(posedge Ck or negedge reset_) begin
        if (!reset_) begin
            Z_q       <= 1'b0;
            match_cnt <= '0;
        end else begin
            Z_q <= Z;
            if (cnt_clr)                         match_cnt <= '0;
            else if (Z && match_cnt != CNT_MAX)  match_cnt <= match_cnt + 1'b1;
        end
    end
endmodule
